// File: rtl/aska_dig.sv
// aska_dig: digital core of the ASKA pulse generator.
// Contains a write-only SPI slave that loads four configuration registers,
// and a 20 kHz sequencer that drives biphasic pulses onto the H-bridge masks
// and the current DAC. The pulses follow a repeating ramp-up / on /
// ramp-down / off pattern.
module aska_dig (
   input  logic        clk,
   input  logic        reset_l,
   input  logic        porborn,
   input  logic        SPI_CS,
   input  logic        SPI_Clk,
   input  logic        SPI_MOSI,
   output logic [31:0] up_switches,
   output logic [31:0] down_switches,
   output logic [5:0]  DAC,
   output logic        pulse_active,
   output logic        enable
);

   typedef enum logic [2:0] {S_IDLE, S_RAMP_UP, S_ON, S_RAMP_DOWN, S_OFF} state_t;

   logic rst_n;
   assign rst_n = reset_l & porborn;

   // ------------------------------------------------------------------ SPI domain
   // The bit count restarts on the first SPI_Clk edge of a frame rather than
   // on CS rising, so that the count and the shift register stay frozen while
   // the clk domain decides whether to commit.
   logic        spi_run_n;
   logic        first_q;
   logic [39:0] sh_q, sh_d;
   logic [5:0]  bits_q, bits_d;

   assign spi_run_n = rst_n & ~SPI_CS;

   // first-bit marker, re-armed whenever the slave is deselected or in reset
   always_ff @(posedge SPI_Clk or negedge spi_run_n) begin
      if (!spi_run_n) first_q <= 1'b1;
      else            first_q <= 1'b0;
   end

   // next shift-register contents and saturating bit count
   always_comb begin
      sh_d   = sh_q;
      bits_d = bits_q;
      if (!SPI_CS) begin
         sh_d = {sh_q[38:0], SPI_MOSI};
         if (first_q)                bits_d = 6'd1;
         else if (bits_q != 6'h3F)   bits_d = bits_q + 6'd1;
      end
   end

   // SPI shift register and bit counter
   always_ff @(posedge SPI_Clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q   <= '0;
         bits_q <= '0;
      end else begin
         sh_q   <= sh_d;
         bits_q <= bits_d;
      end
   end

   // ------------------------------------------------------------------ clk domain
   logic [2:0]  cs_sync_q, cs_sync_d;
   logic        commit;
   logic [31:0] conf0_q, conf0_d, el1_q, el1_d, el2_q, el2_d;
   logic [23:0] conf1_q, conf1_d;   // conf1[31:24] has no function

   // Frame commit: a CS rising edge seen after two sync flops, with exactly
   // 40 bits received and an address in 0..3.
   always_comb begin
      cs_sync_d = {cs_sync_q[1:0], SPI_CS};
      commit    = cs_sync_q[1] & ~cs_sync_q[2] & (bits_q == 6'd40) & (sh_q[39:34] == 6'd0);
      conf0_d   = conf0_q;
      conf1_d   = conf1_q;
      el1_d     = el1_q;
      el2_d     = el2_q;
      if (commit) begin
         case (sh_q[33:32])
            2'd0:    conf0_d = sh_q[31:0];
            2'd1:    conf1_d = sh_q[23:0];
            2'd2:    el1_d   = sh_q[31:0];
            default: el2_d   = sh_q[31:0];
         endcase
      end
   end

   // CS synchronizer and configuration registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_sync_q <= 3'b111;
         conf0_q   <= '0;
         conf1_q   <= '0;
         el1_q     <= '0;
         el2_q     <= '0;
      end else begin
         cs_sync_q <= cs_sync_d;
         conf0_q   <= conf0_d;
         conf1_q   <= conf1_d;
         el1_q     <= el1_d;
         el2_q     <= el2_d;
      end
   end

   logic [11:0] freq;
   logic [5:0]  amplitude, ramp;
   logic [7:0]  on_time;
   logic [9:0]  ramp_factor, off_time;
   logic        en;
   logic [3:0]  pd;

   assign freq        = conf0_q[11:0];
   assign amplitude   = conf0_q[17:12];
   assign ramp        = conf0_q[23:18];
   assign on_time     = conf0_q[31:24];
   assign ramp_factor = conf1_q[9:0];
   assign off_time    = conf1_q[19:10];
   assign en          = conf1_q[20];
   assign pd          = (conf1_q[23:21] == 3'd0) ? 4'd1 : {1'b0, conf1_q[23:21]};
   assign enable      = en;

   // ------------------------------------------------------------------ sequencer
   function automatic logic [9:0] count_of(input state_t s, input logic [5:0] r,
                                           input logic [7:0] on_n, input logic [9:0] off_n);
      case (s)
         S_RAMP_UP, S_RAMP_DOWN: count_of = {4'd0, r};
         S_ON:                   count_of = {2'd0, on_n};
         S_OFF:                  count_of = off_n;
         default:                count_of = 10'd0;
      endcase
   endfunction

   function automatic state_t succ(input state_t s);
      case (s)
         S_RAMP_UP:   succ = S_ON;
         S_ON:        succ = S_RAMP_DOWN;
         S_RAMP_DOWN: succ = S_OFF;
         default:     succ = S_RAMP_UP;
      endcase
   endfunction

   // amplitude accumulator value for the period about to start in state s
   function automatic logic [10:0] acc_step(input state_t s, input logic [10:0] acc,
                                            input logic [9:0] rf, input logic [5:0] amp);
      logic [11:0] sum;
      logic [10:0] top;
      top = {1'b0, amp, 4'd0};
      sum = {1'b0, acc} + {2'd0, rf};
      case (s)
         S_RAMP_UP:   acc_step = (sum > {1'b0, top}) ? top : sum[10:0];
         S_ON:        acc_step = top;
         S_RAMP_DOWN: acc_step = (acc > {1'b0, rf}) ? (acc - {1'b0, rf}) : 11'd0;
         default:     acc_step = acc;
      endcase
   endfunction

   state_t      state_q, state_d, live_next, cand;
   logic        found;
   logic [11:0] cyc_q, cyc_d;
   logic [9:0]  cnt_q, cnt_d;
   logic [10:0] acc_q, acc_d;
   logic [31:0] up_q, up_d, down_q, down_d;
   logic [5:0]  dac_q, dac_d;
   logic        pa_q, pa_d;
   logic        pulsing, ph1, ph2;

   // First state after the current one whose count is nonzero; with every
   // count at zero the sequencer parks in OFF. From IDLE the search starts
   // as if leaving OFF, so RAMP_UP is tried first.
   always_comb begin
      cand      = succ((state_q == S_IDLE) ? S_OFF : state_q);
      live_next = S_OFF;
      found     = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (!found && (count_of(cand, ramp, on_time, off_time) != 10'd0)) begin
            live_next = cand;
            found     = 1'b1;
         end
         cand = succ(cand);
      end
   end

   // next state, period counter, per-state period count and accumulator
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      if (!en) begin
         state_d = S_IDLE;
         cyc_d   = '0;
         cnt_d   = '0;
         acc_d   = '0;
      end else if (state_q == S_IDLE) begin
         state_d = live_next;
         cyc_d   = '0;
         cnt_d   = '0;
         acc_d   = acc_step(live_next, 11'd0, ramp_factor, amplitude);
      end else if (freq != 12'd0) begin
         if (cyc_q >= freq - 12'd1) begin
            cyc_d = '0;
            if (({1'b0, cnt_q} + 11'd1) >= {1'b0, count_of(state_q, ramp, on_time, off_time)}) begin
               state_d = live_next;
               cnt_d   = '0;
               acc_d   = acc_step(live_next, acc_q, ramp_factor, amplitude);
            end else begin
               cnt_d = cnt_q + 10'd1;
               acc_d = acc_step(state_q, acc_q, ramp_factor, amplitude);
            end
         end else begin
            cyc_d = cyc_q + 12'd1;
         end
      end
   end

   // pulse phase decode; outputs forced low whenever disabled or freq is 0
   always_comb begin
      pulsing = en && (freq != 12'd0) &&
                (state_q == S_RAMP_UP || state_q == S_ON || state_q == S_RAMP_DOWN);
      ph1     = cyc_q < {8'd0, pd};
      ph2     = !ph1 && (cyc_q < {7'd0, pd, 1'b0});
      up_d    = '0;
      down_d  = '0;
      if (pulsing && ph1) begin
         up_d   = el1_q;
         down_d = el2_q;
      end else if (pulsing && ph2) begin
         up_d   = el2_q;
         down_d = el1_q;
      end
      pa_d  = pulsing && (ph1 || ph2);
      dac_d = pa_d ? acc_q[9:4] : 6'd0;
   end

   // sequencer state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cyc_q   <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         up_q    <= '0;
         down_q  <= '0;
         dac_q   <= '0;
         pa_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         up_q    <= up_d;
         down_q  <= down_d;
         dac_q   <= dac_d;
         pa_q    <= pa_d;
      end
   end

   assign up_switches   = up_q;
   assign down_switches = down_q;
   assign DAC           = dac_q;
   assign pulse_active  = pa_q;

endmodule

// File: tb/tb_aska_dig.sv
// tb_aska_dig: directed bench for aska_dig (SPI configuration, pulse shape,
// ramp profile, enable/disable, discarded frames and both reset inputs).
`timescale 1ns/1ns
module tb_aska_dig;

   localparam logic [31:0] EL1 = 32'h0000_8000;
   localparam logic [31:0] EL2 = 32'h0000_4000;

   logic        clk = 1'b0;
   logic        reset_l = 1'b1;
   logic        porborn = 1'b1;
   logic        SPI_CS = 1'b1;
   logic        SPI_Clk = 1'b0;
   logic        SPI_MOSI = 1'b0;
   logic [31:0] up_switches, down_switches;
   logic [5:0]  DAC;
   logic        pulse_active, enable;

   int n_tests = 0;
   int n_fail  = 0;
   int pst[$];
   logic [5:0] pdac[$];

   aska_dig dut (
      .clk(clk), .reset_l(reset_l), .porborn(porborn),
      .SPI_CS(SPI_CS), .SPI_Clk(SPI_Clk), .SPI_MOSI(SPI_MOSI),
      .up_switches(up_switches), .down_switches(down_switches),
      .DAC(DAC), .pulse_active(pulse_active), .enable(enable)
   );

   // 20 kHz system clock
   always #25000 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // one SPI frame, mode 0, 500 kHz, first nbits of {addr,data} MSB first
   task automatic spi_send(input logic [7:0] addr, input logic [31:0] data, input int nbits);
      logic [39:0] word;
      word = {addr, data};
      $display("[TB] spi frame addr=0x%02h data=0x%08h bits=%0d", addr, data, nbits);
      SPI_CS = 1'b0;
      #1000;
      for (int i = 0; i < nbits; i++) begin
         SPI_MOSI = word[39-i];
         #1000 SPI_Clk = 1'b1;
         #1000 SPI_Clk = 1'b0;
      end
      #1000 SPI_CS = 1'b1;
   endtask

   task automatic spi_write(input logic [7:0] addr, input logic [31:0] data, input int nbits);
      spi_send(addr, data, nbits);
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_pulse(output int lat, input int limit);
      lat = 0;
      while (pulse_active !== 1'b1 && lat < limit) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // record start cycle and DAC code of every pulse over ncyc cycles
   task automatic monitor(input int ncyc);
      logic prev;
      pst.delete();
      pdac.delete();
      prev = pulse_active;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         if (pulse_active && !prev) begin
            pst.push_back(c);
            pdac.push_back(DAC);
         end
         prev = pulse_active;
      end
   endtask

   // cycle-exact check of one period; entered on its first pulse cycle
   task automatic check_period(input string tag, input logic [5:0] dac, input int pd, input int freq);
      int bad;
      logic [31:0] eu, ed;
      logic ep;
      bad = 0;
      for (int i = 0; i < freq; i++) begin
         eu = (i < pd) ? EL1 : (i < 2*pd) ? EL2 : 32'h0;
         ed = (i < pd) ? EL2 : (i < 2*pd) ? EL1 : 32'h0;
         ep = (i < 2*pd);
         if (i == 0) begin
            check({tag, "_ph1_up"},  up_switches,   EL1);
            check({tag, "_ph1_dn"},  down_switches, EL2);
            check({tag, "_ph1_dac"}, {26'd0, DAC},  {26'd0, dac});
         end
         if (i == pd) begin
            check({tag, "_ph2_up"}, up_switches,   EL2);
            check({tag, "_ph2_dn"}, down_switches, EL1);
         end
         if (up_switches !== eu || down_switches !== ed || pulse_active !== ep ||
             DAC !== (ep ? dac : 6'd0))
            bad++;
         @(negedge clk);
      end
      check({tag, "_bad_cycles"}, bad, 0);
      check({tag, "_next_start"}, {31'd0, pulse_active}, 1);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_up"},  up_switches,   0);
      check({tag, "_dn"},  down_switches, 0);
      check({tag, "_dac"}, {26'd0, DAC},  0);
      check({tag, "_pa"},  {31'd0, pulse_active}, 0);
      check({tag, "_en"},  {31'd0, enable}, 0);
   endtask

   initial begin
      int lat, n, w;
      logic [5:0] exp_dac;

      // ---- reset via reset_l
      #10 reset_l = 1'b0;
      repeat (3) @(negedge clk);
      check_quiet("rst");
      reset_l = 1'b1;
      @(negedge clk);

      // ---- configuration and first periods at freq = 400
      spi_write(8'h02, EL1, 40);
      spi_write(8'h03, EL2, 40);
      spi_write(8'h00, 32'h32CB2190, 40);
      check("en_before", {31'd0, enable}, 0);
      spi_send(8'h01, 32'h0090C810, 40);
      wait_pulse(lat, 10);
      check("start_seen", {31'd0, pulse_active}, 1);
      check("start_lat_le6", {31'd0, lat <= 6}, 1);
      check("enable_out", {31'd0, enable}, 1);
      check_period("p1", 6'd1, 4, 400);
      check_period("p2", 6'd2, 4, 400);
      check("p3_dac", {26'd0, DAC}, 3);

      // ---- disable mid-pulse
      spi_send(8'h01, 32'h0080C810, 40);
      n = 0;
      while (enable === 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      check("dis_enable", {31'd0, enable}, 0);
      check("dis_mid_pulse", {31'd0, pulse_active}, 1);
      @(negedge clk);
      check_quiet("dis_forced");
      monitor(500);
      check("dis_no_pulses", pst.size(), 0);

      // ---- full sequence at freq = 10
      spi_write(8'h00, 32'h32CB200A, 40);
      spi_send(8'h01, 32'h0090C810, 40);
      monitor(2200);
      check("full_npulses_ge151", {31'd0, pst.size() >= 151}, 1);
      for (int k = 0; k < 151 && k < pst.size(); k++) begin
         exp_dac = (k < 50) ? 6'(k + 1) : (k < 100) ? 6'd50 : (k < 150) ? 6'(149 - k) : 6'd1;
         check($sformatf("full_dac_%0d", k), {26'd0, pdac[k]}, {26'd0, exp_dac});
         if (k > 0)
            check($sformatf("full_gap_%0d", k), pst[k] - pst[k-1], (k == 150) ? 510 : 10);
      end

      // ---- discarded frames
      spi_write(8'h01, 32'h0, 32);
      check("trunc_enable", {31'd0, enable}, 1);
      spi_write(8'h05, 32'h0, 40);
      check("addr5_enable", {31'd0, enable}, 1);
      monitor(100);
      check("still_pulsing", {31'd0, pst.size() >= 9}, 1);

      // ---- re-enable with amplitude 25, ramp 25
      spi_write(8'h01, 32'h0080C810, 40);
      check("re_dis", {31'd0, enable}, 0);
      spi_write(8'h00, 32'h3265900A, 40);
      spi_send(8'h01, 32'h0090C810, 40);
      monitor(400);
      check("re_npulses_ge30", {31'd0, pst.size() >= 30}, 1);
      for (int k = 0; k < 30 && k < pst.size(); k++)
         check($sformatf("re_dac_%0d", k), {26'd0, pdac[k]}, (k < 25) ? k + 1 : 25);

      // ---- reset_l during a pulse
      wait_pulse(lat, 20);
      check("rstp_seen", {31'd0, pulse_active}, 1);
      reset_l = 1'b0;
      #1;
      check_quiet("rstp");
      reset_l = 1'b1;
      monitor(100);
      check("rstp_no_pulses", pst.size(), 0);
      check("rstp_en", {31'd0, enable}, 0);

      // ---- freq = 0 gives no pulses; phaseDuration 0 acts as 1
      spi_write(8'h02, EL1, 40);
      spi_write(8'h03, EL2, 40);
      spi_write(8'h00, 32'h32CB2000, 40);
      spi_write(8'h01, 32'h0010C810, 40);
      monitor(200);
      check("f0_no_pulses", pst.size(), 0);
      check("f0_en", {31'd0, enable}, 1);
      spi_send(8'h00, 32'h32CB200A, 40);
      wait_pulse(lat, 10);
      check("pd0_seen", {31'd0, pulse_active}, 1);
      check("pd0_up", up_switches, EL1);
      check("pd0_dac", {26'd0, DAC}, 1);
      w = 0;
      while (pulse_active === 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("pd0_width", w, 2);

      // ---- porborn during a pulse
      wait_pulse(lat, 20);
      check("por_seen", {31'd0, pulse_active}, 1);
      porborn = 1'b0;
      #1;
      check_quiet("por");
      porborn = 1'b1;
      monitor(100);
      check("por_no_pulses", pst.size(), 0);
      check("por_en", {31'd0, enable}, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // overall time bound
   initial begin
      #1000000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
